// File: rtl/ehgu_multimode_counter.sv
// rtl/ehgu_multimode_counter.sv - multimode counter engine (modulo, saturate, gray, LFSR)
// One count register with registered gray view and single-cycle event pulses.
module ehgu_multimode_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY   = 8'hB8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic             en_i,
  input  logic             dir_up_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH:0]   limit_i,
  input  logic [WIDTH-1:0] minimum_i,
  input  logic [WIDTH-1:0] maximum_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrapped_o,
  output logic             saturated_o,
  output logic             lock_o
);

  typedef enum logic [1:0] {
    MODE_MODULO   = 2'd0,
    MODE_SATURATE = 2'd1,
    MODE_GRAY     = 2'd2,
    MODE_LFSR     = 2'd3
  } mode_e;

  localparam logic [WIDTH:0]   FULL_RANGE = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            mode;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wrapped_q, wrapped_d;
  logic             saturated_q, saturated_d;
  logic             lock_q, lock_d;

  // All arithmetic is carried one bit wider than the count so sums never truncate.
  logic [WIDTH:0]   ext_count, ext_step, modulus, sum;
  logic [WIDTH:0]   mod_up_val, mod_dn_val, sat_floor;
  logic             mod_up_wrap, mod_dn_wrap, sat_up_clamp, sat_dn_clamp;
  logic [WIDTH-1:0] gray_next;
  logic             gray_wrap;
  logic             lfsr_fb, lfsr_zero;
  logic [WIDTH-1:0] lfsr_next;

  assign mode         = mode_e'(mode_i);
  assign ext_count    = {1'b0, count_q};
  assign ext_step     = {1'b0, step_i};
  assign modulus      = (limit_i == '0) ? FULL_RANGE : limit_i;
  assign sum          = ext_count + ext_step;

  assign mod_up_wrap  = (sum >= modulus);
  assign mod_up_val   = mod_up_wrap ? (sum - modulus) : sum;
  assign mod_dn_wrap  = (ext_count < ext_step);
  assign mod_dn_val   = mod_dn_wrap ? ((ext_count + modulus) - ext_step) : (ext_count - ext_step);

  assign sat_floor    = {1'b0, minimum_i} + ext_step;
  assign sat_up_clamp = (sum > {1'b0, maximum_i});
  assign sat_dn_clamp = (ext_count < sat_floor);

  assign gray_next    = count_q + ONE;
  assign gray_wrap    = &count_q;

  // All-zero is the LFSR lock-up state; escape to 1 instead of shifting.
  assign lfsr_fb      = ^(count_q & LFSR_POLY);
  assign lfsr_zero    = (count_q == '0);
  assign lfsr_next    = lfsr_zero ? ONE : {lfsr_fb, count_q[WIDTH-1:1]};

  always_comb begin
    count_d     = count_q;
    seed_d      = seed_q;
    wrapped_d   = 1'b0;
    saturated_d = 1'b0;
    lock_d      = 1'b0;
    if (load_i) begin
      count_d = load_value_i;
      seed_d  = load_value_i;
    end else if (en_i) begin
      unique case (mode)
        MODE_MODULO: begin
          if (dir_up_i) begin
            count_d   = mod_up_val[WIDTH-1:0];
            wrapped_d = mod_up_wrap;
          end else begin
            count_d   = mod_dn_val[WIDTH-1:0];
            wrapped_d = mod_dn_wrap;
          end
        end
        MODE_SATURATE: begin
          if (dir_up_i) begin
            count_d     = sat_up_clamp ? maximum_i : sum[WIDTH-1:0];
            saturated_d = sat_up_clamp;
          end else begin
            count_d     = sat_dn_clamp ? minimum_i : (count_q - step_i);
            saturated_d = sat_dn_clamp;
          end
        end
        MODE_GRAY: begin
          count_d   = gray_next;
          wrapped_d = gray_wrap;
        end
        MODE_LFSR: begin
          count_d   = lfsr_next;
          lock_d    = lfsr_zero;
          wrapped_d = (lfsr_next == seed_q);
        end
        default: count_d = count_q;
      endcase
    end
    gray_d = count_d ^ (count_d >> 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q     <= RESET_VALUE;
      gray_q      <= RESET_VALUE ^ (RESET_VALUE >> 1);
      seed_q      <= RESET_VALUE;
      wrapped_q   <= 1'b0;
      saturated_q <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      gray_q      <= gray_d;
      seed_q      <= seed_d;
      wrapped_q   <= wrapped_d;
      saturated_q <= saturated_d;
      lock_q      <= lock_d;
    end
  end

  assign count_o     = count_q;
  assign gray_o      = gray_q;
  assign wrapped_o   = wrapped_q;
  assign saturated_o = saturated_q;
  assign lock_o      = lock_q;

endmodule

// File: tb/tb_ehgu_multimode_counter.sv
// tb/tb_ehgu_multimode_counter.sv - directed self-checking bench for ehgu_multimode_counter
module tb_ehgu_multimode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       en = 1'b0;
  logic       dir_up = 1'b1;
  logic [7:0] step = 8'd0;
  logic [8:0] limit = 9'd0;
  logic [7:0] minimum = 8'd0;
  logic [7:0] maximum = 8'd255;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic [7:0] count, gray;
  logic       wrapped, saturated, lock;

  int n_cmp = 0;
  int n_fail = 0;

  ehgu_multimode_counter #(.WIDTH(8), .LFSR_POLY(8'hB8), .RESET_VALUE(8'h00)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .en_i(en), .dir_up_i(dir_up),
    .step_i(step), .limit_i(limit), .minimum_i(minimum), .maximum_i(maximum),
    .load_i(load), .load_value_i(load_value), .count_o(count), .gray_o(gray),
    .wrapped_o(wrapped), .saturated_o(saturated), .lock_o(lock)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v; en = 1'b0;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_step();
    en = 1'b1;
    cycle();
    en = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_ref(input logic [7:0] s);
    if (s == 8'h00) return 8'h01;
    return {^(s & 8'hB8), s[7:1]};
  endfunction

  task automatic test_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    n_cmp++; if (count !== 8'h00) begin $display("FAIL reset_count: got %h expected %h", count, 8'h00); n_fail++; end
    n_cmp++; if (gray !== 8'h00) begin $display("FAIL reset_gray: got %h expected %h", gray, 8'h00); n_fail++; end
    n_cmp++; if ({wrapped, saturated, lock} !== 3'b000) begin $display("FAIL reset_pulses: got %b expected 000", {wrapped, saturated, lock}); n_fail++; end
  endtask

  task automatic test_modulo_up();
    mode = 2'd0; limit = 9'd10; step = 8'd3; dir_up = 1'b1;
    do_load(8'd8);
    do_step();
    n_cmp++; if (count !== 8'd1) begin $display("FAIL mod_up_wrap_count: got %0d expected 1", count); n_fail++; end
    n_cmp++; if (wrapped !== 1'b1) begin $display("FAIL mod_up_wrap_pulse: got %b expected 1", wrapped); n_fail++; end
    do_step();
    n_cmp++; if (count !== 8'd4) begin $display("FAIL mod_up_next_count: got %0d expected 4", count); n_fail++; end
    n_cmp++; if (wrapped !== 1'b0) begin $display("FAIL mod_up_next_pulse: got %b expected 0", wrapped); n_fail++; end
    n_cmp++; if (gray !== 8'h06) begin $display("FAIL mod_up_gray: got %h expected 06", gray); n_fail++; end
    cycle();
    n_cmp++; if (count !== 8'd4) begin $display("FAIL mod_hold_count: got %0d expected 4", count); n_fail++; end
    limit = 9'd0; step = 8'd1;
    do_load(8'd255);
    do_step();
    n_cmp++; if ({count, wrapped} !== {8'd0, 1'b1}) begin $display("FAIL mod_up_full_range: got %0d/%b expected 0/1", count, wrapped); n_fail++; end
  endtask

  task automatic test_modulo_down();
    mode = 2'd0; limit = 9'd10; step = 8'd3; dir_up = 1'b0;
    do_load(8'd1);
    do_step();
    n_cmp++; if (count !== 8'd8) begin $display("FAIL mod_dn_wrap_count: got %0d expected 8", count); n_fail++; end
    n_cmp++; if (wrapped !== 1'b1) begin $display("FAIL mod_dn_wrap_pulse: got %b expected 1", wrapped); n_fail++; end
    do_step();
    n_cmp++; if ({count, wrapped} !== {8'd5, 1'b0}) begin $display("FAIL mod_dn_plain: got %0d/%b expected 5/0", count, wrapped); n_fail++; end
    limit = 9'd0; step = 8'd1;
    do_load(8'd0);
    do_step();
    n_cmp++; if ({count, wrapped} !== {8'd255, 1'b1}) begin $display("FAIL mod_dn_full_range: got %0d/%b expected 255/1", count, wrapped); n_fail++; end
  endtask

  task automatic test_saturate();
    mode = 2'd1; maximum = 8'd200; minimum = 8'd0; step = 8'd60; dir_up = 1'b1;
    do_load(8'd180);
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd200, 1'b1}) begin $display("FAIL sat_up_clamp: got %0d/%b expected 200/1", count, saturated); n_fail++; end
    n_cmp++; if (gray !== 8'hAC) begin $display("FAIL sat_up_gray: got %h expected ac", gray); n_fail++; end
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd200, 1'b1}) begin $display("FAIL sat_up_reflag: got %0d/%b expected 200/1", count, saturated); n_fail++; end
    step = 8'd10;
    do_load(8'd190);
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd200, 1'b0}) begin $display("FAIL sat_up_exact: got %0d/%b expected 200/0", count, saturated); n_fail++; end
    maximum = 8'd255;
    do_load(8'd250);
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd255, 1'b1}) begin $display("FAIL sat_up_overflow: got %0d/%b expected 255/1", count, saturated); n_fail++; end
    dir_up = 1'b0; minimum = 8'd5;
    do_load(8'd15);
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd5, 1'b0}) begin $display("FAIL sat_dn_exact: got %0d/%b expected 5/0", count, saturated); n_fail++; end
    do_step();
    n_cmp++; if ({count, saturated} !== {8'd5, 1'b1}) begin $display("FAIL sat_dn_clamp: got %0d/%b expected 5/1", count, saturated); n_fail++; end
  endtask

  task automatic test_gray();
    mode = 2'd2; step = 8'd3; dir_up = 1'b0; limit = 9'd10;
    do_load(8'h7F);
    do_step();
    n_cmp++; if ({count, gray} !== {8'h80, 8'hC0}) begin $display("FAIL gray_step: got %h/%h expected 80/c0", count, gray); n_fail++; end
    n_cmp++; if (wrapped !== 1'b0) begin $display("FAIL gray_nowrap: got %b expected 0", wrapped); n_fail++; end
    do_load(8'hFF);
    n_cmp++; if (gray !== 8'h80) begin $display("FAIL gray_after_load: got %h expected 80", gray); n_fail++; end
    do_step();
    n_cmp++; if ({count, gray, wrapped} !== {8'h00, 8'h00, 1'b1}) begin $display("FAIL gray_wrap: got %h/%h/%b expected 00/00/1", count, gray, wrapped); n_fail++; end
  endtask

  task automatic test_lfsr();
    logic [7:0] s, sd;
    int p, k;
    logic seen;
    mode = 2'd3;
    do_load(8'h80);
    do_step();
    n_cmp++; if ({count, lock, wrapped} !== {8'hC0, 1'b0, 1'b0}) begin $display("FAIL lfsr_first: got %h/%b/%b expected c0/0/0", count, lock, wrapped); n_fail++; end
    do_load(8'h00);
    do_step();
    n_cmp++; if ({count, lock, wrapped} !== {8'h01, 1'b1, 1'b0}) begin $display("FAIL lfsr_escape: got %h/%b/%b expected 01/1/0", count, lock, wrapped); n_fail++; end
    do_step();
    n_cmp++; if ({count, lock, wrapped} !== {8'h00, 1'b0, 1'b1}) begin $display("FAIL lfsr_back_to_seed0: got %h/%b/%b expected 00/0/1", count, lock, wrapped); n_fail++; end
    do_load(8'h80);
    s = 8'h80;
    for (int i = 0; i < 20; i++) begin
      s = lfsr_ref(s);
      do_step();
      n_cmp++; if (count !== s) begin $display("FAIL lfsr_walk_%0d: got %h expected %h", i, count, s); n_fail++; end
    end
    sd = 8'h80;
    for (int i = 0; i < 300; i++) sd = lfsr_ref(sd);
    s = sd; p = 0;
    do begin s = lfsr_ref(s); p++; end while (s != sd && p < 300);
    do_load(sd);
    en = 1'b1; k = 0; seen = 1'b0;
    while (!seen && k < 600) begin
      cycle(); k++;
      seen = wrapped;
    end
    en = 1'b0;
    n_cmp++; if (seen !== 1'b1) begin $display("FAIL lfsr_wrap_timeout: got no wrap in %0d cycles expected wrap", k); n_fail++; end
    n_cmp++; if (count !== sd) begin $display("FAIL lfsr_wrap_state: got %h expected %h", count, sd); n_fail++; end
    n_cmp++; if (k !== p) begin $display("FAIL lfsr_wrap_period: got %0d expected %0d", k, p); n_fail++; end
  endtask

  task automatic test_mode_switch();
    mode = 2'd0; limit = 9'd10; step = 8'd3; dir_up = 1'b1;
    do_load(8'd6);
    do_step();
    n_cmp++; if (count !== 8'd9) begin $display("FAIL switch_modulo: got %0d expected 9", count); n_fail++; end
    mode = 2'd1;
    cycle();
    n_cmp++; if ({count, saturated} !== {8'd9, 1'b0}) begin $display("FAIL switch_hold: got %0d/%b expected 9/0", count, saturated); n_fail++; end
    mode = 2'd2;
    do_step();
    n_cmp++; if ({count, wrapped} !== {8'd10, 1'b0}) begin $display("FAIL switch_gray: got %0d/%b expected 10/0", count, wrapped); n_fail++; end
  endtask

  task automatic test_priority();
    mode = 2'd0; limit = 9'd10; step = 8'd3; dir_up = 1'b1;
    do_load(8'd9);
    load = 1'b1; load_value = 8'd5; en = 1'b1;
    cycle();
    load = 1'b0;
    n_cmp++; if ({count, gray, wrapped} !== {8'd5, 8'd7, 1'b0}) begin $display("FAIL prio_load_over_en: got %0d/%h/%b expected 5/07/0", count, gray, wrapped); n_fail++; end
    cycle();
    en = 1'b0;
    n_cmp++; if (count !== 8'd8) begin $display("FAIL prio_then_en: got %0d expected 8", count); n_fail++; end
    en = 1'b1;
    cycle();
    n_cmp++; if ({count, wrapped} !== {8'd1, 1'b1}) begin $display("FAIL prio_prewrap: got %0d/%b expected 1/1", count, wrapped); n_fail++; end
    rst = 1'b1; load = 1'b1; load_value = 8'h44;
    cycle();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    n_cmp++; if ({count, gray} !== {8'h00, 8'h00}) begin $display("FAIL prio_rst_count: got %h/%h expected 00/00", count, gray); n_fail++; end
    n_cmp++; if ({wrapped, saturated, lock} !== 3'b000) begin $display("FAIL prio_rst_pulses: got %b expected 000", {wrapped, saturated, lock}); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_modulo_up();
    test_modulo_down();
    test_saturate();
    test_gray();
    test_lfsr();
    test_mode_switch();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
